// File: rtl/apb_slave.sv
// ---------------------------------------------------------------------------
// apb_slave
//   APB slave front end for a timer register file. It tracks the APB
//   SETUP/ACCESS phases, optionally inserts WAIT_STATES extra access cycles,
//   and emits one-cycle completion strobes toward the register file.
//
// Handshake: a transfer opens when tim_psel=1 with tim_penable=0 (SETUP). It
//   completes on the edge where tim_psel=1 and tim_penable=1 have been held
//   for WAIT_STATES+1 consecutive edges. On that edge tim_pready, wr_en or
//   rd_en, and tim_pslverr are registered high for exactly one cycle.
//   Dropping tim_psel, or tim_penable once it has been raised, abandons the
//   transfer with no strobes.
//
// Parameters
//   WAIT_STATES    : extra ACCESS cycles before completion (0..15)
// Ports
//   sys_clk        : clock, rising edge
//   sys_rst_n      : asynchronous active-low reset
//   tim_psel       : APB select
//   tim_pwrite     : 1 = write, 0 = read
//   tim_penable    : APB enable (access phase)
//   reg_error_flag : register-file error for the current access
//   tim_pready     : transfer complete (registered, one cycle)
//   tim_pslverr    : transfer error, only ever high together with tim_pready
//   wr_en          : register write strobe (registered, one cycle)
//   rd_en          : register read strobe (registered, one cycle)
//   dbg_state      : current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
// ---------------------------------------------------------------------------
module apb_slave #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tim_psel,
  input  logic       tim_pwrite,
  input  logic       tim_penable,
  input  logic       reg_error_flag,
  output logic       tim_pready,
  output logic       tim_pslverr,
  output logic       wr_en,
  output logic       rd_en,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // Counter value on the final ACCESS edge; unused when WAIT_STATES is 0.
  localparam logic [3:0] LAST_CNT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic       done;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done      = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    wr_d      = 1'b0;
    rd_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // penable without a preceding setup cycle is not a transfer.
        if (tim_psel && !tim_penable) begin
          state_d = ST_SETUP;
        end
        cnt_d = 4'd0;
      end

      ST_SETUP: begin
        if (!tim_psel) begin
          state_d = ST_IDLE;
        end else if (tim_penable) begin
          if (WAIT_STATES == 0) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = 4'd0;
          end
        end
      end

      ST_ACCESS: begin
        if (tim_psel && tim_penable) begin
          if (cnt_q == LAST_CNT) begin
            done    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Strobes are only raised for the completion edge; default 0 makes them
    // one-cycle pulses and keeps pslverr tied to pready.
    if (done) begin
      pready_d  = 1'b1;
      wr_d      = tim_pwrite;
      rd_d      = !tim_pwrite;
      pslverr_d = reg_error_flag;
    end
  end

  assign tim_pready  = pready_q;
  assign tim_pslverr = pslverr_q;
  assign wr_en       = wr_q;
  assign rd_en       = rd_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_slave
//   Drives one shared APB input stream into two instances (WAIT_STATES 0 and
//   2) and checks each against a transaction-level reference: a transfer is
//   opened by a setup cycle and completes after WAIT_STATES+1 consecutive
//   enabled edges; anything else abandons it.
// ---------------------------------------------------------------------------
module tb_apb_slave;

  logic       clk;
  logic       rst_n;
  logic       psel, pwrite, penable, err_flag;
  logic [1:0] pready, pslverr, wr, rd;
  logic [1:0] dbg0, dbg2;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 -> WAIT_STATES 0, index 1 -> WAIT_STATES 2.
  int  ws_of [2] = '{0, 2};
  bit  open_q [2];
  int  en_edges [2];
  logic [3:0] exp_q [$];  // {pready, pslverr, wr, rd} per instance

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #50 clk = ~clk;

  apb_slave #(.WAIT_STATES(0)) u_dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tim_psel(psel), .tim_pwrite(pwrite),
    .tim_penable(penable), .reg_error_flag(err_flag),
    .tim_pready(pready[0]), .tim_pslverr(pslverr[0]), .wr_en(wr[0]),
    .rd_en(rd[0]), .dbg_state(dbg0)
  );

  apb_slave #(.WAIT_STATES(2)) u_dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .tim_psel(psel), .tim_pwrite(pwrite),
    .tim_penable(penable), .reg_error_flag(err_flag),
    .tim_pready(pready[1]), .tim_pslverr(pslverr[1]), .wr_en(wr[1]),
    .rd_en(rd[1]), .dbg_state(dbg2)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    assert (act === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (pready,pslverr,wr,rd) t=%0t", tag, act, exp_v, $time);
    end
  endtask

  task automatic chk_outputs(input string tag);
    logic [3:0] e;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_ws%0d", tag, ws_of[i]), {pready[i], pslverr[i], wr[i], rd[i]}, e);
      checks++;
      assert (!(wr[i] && rd[i]) && !(pslverr[i] && !pready[i])) else begin
        errors++;
        $error("FAIL %s_ws%0d_excl observed wr=%b rd=%b pslverr=%b pready=%b expected exclusive strobes",
               tag, ws_of[i], wr[i], rd[i], pslverr[i], pready[i]);
      end
    end
  endtask

  // Advance the reference by one clock edge using the inputs just sampled.
  task automatic model_edge(input logic s, input logic en, input logic w, input logic er);
    for (int i = 0; i < 2; i++) begin
      logic [3:0] e;
      e = 4'b0000;
      if (!open_q[i]) begin
        if (s && !en) begin
          open_q[i]   = 1'b1;
          en_edges[i] = 0;
        end
      end else if (s && en) begin
        en_edges[i]++;
        if (en_edges[i] == ws_of[i] + 1) begin
          e         = {1'b1, er, w, !w};
          open_q[i] = 1'b0;
        end
      end else if (s && !en && en_edges[i] == 0) begin
        // still in the setup phase
      end else begin
        open_q[i] = 1'b0;
      end
      exp_q.push_back(e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic s, input logic en, input logic w, input logic er, input string tag);
    psel = s; penable = en; pwrite = w; err_flag = er;
    @(posedge clk);
    model_edge(s, en, w, er);
    #1;
    chk_outputs(tag);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #10;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      open_q[i] = 1'b0;
      en_edges[i] = 0;
      exp_q.push_back(4'b0000);
    end
    chk_outputs({tag, "_imm"});
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; err_flag = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) exp_q.push_back(4'b0000);
    chk_outputs({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; psel = 0; penable = 0; pwrite = 0; err_flag = 0;
    for (int i = 0; i < 2; i++) begin open_q[i] = 0; en_edges[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) exp_q.push_back(4'b0000);
    chk_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);  // E1
    #1;

    // Write: setup after E1, enable after E2, strobe after E3, clear after E4.
    step(1, 0, 1, 0, "wr_setup");
    step(1, 1, 1, 0, "wr_access");
    step(0, 0, 0, 0, "wr_after");

    // Read.
    step(1, 0, 0, 0, "rd_setup");
    step(1, 1, 0, 0, "rd_access");
    step(0, 0, 0, 0, "rd_after");

    // Error write.
    step(1, 0, 1, 1, "err_setup");
    step(1, 1, 1, 1, "err_access");
    step(0, 0, 0, 0, "err_after");

    // Abort from setup.
    step(1, 0, 1, 0, "abort_setup");
    step(0, 0, 1, 0, "abort_drop");
    step(0, 0, 1, 0, "abort_idle");

    // penable with no prior setup is ignored.
    step(1, 1, 1, 0, "noset_en");
    step(1, 1, 1, 0, "noset_en2");
    step(0, 0, 0, 0, "noset_idle");

    // Setup held for two cycles, then back-to-back read after a write.
    step(1, 0, 1, 0, "b2b_setup");
    step(1, 0, 1, 0, "b2b_setup2");
    step(1, 1, 1, 0, "b2b_acc1");
    step(1, 0, 0, 0, "b2b_setup3");
    step(1, 1, 0, 0, "b2b_acc2");
    step(0, 0, 0, 0, "b2b_idle");

    // Wait-state write: ws2 instance completes on the third enabled edge.
    step(1, 0, 1, 0, "ws_setup");
    step(1, 1, 1, 0, "ws_acc1");
    step(1, 1, 1, 0, "ws_acc2");
    step(1, 1, 1, 0, "ws_acc3");
    step(0, 0, 0, 0, "ws_after");

    // penable dropped during ACCESS: no completion on the ws2 instance.
    step(1, 0, 0, 0, "wsab_setup");
    step(1, 1, 0, 0, "wsab_acc1");
    step(1, 0, 0, 0, "wsab_drop");
    step(1, 1, 0, 0, "wsab_en_again");
    step(1, 1, 0, 0, "wsab_en_again2");
    step(0, 0, 0, 0, "wsab_idle");

    // Reset mid-transfer, then a clean write straight after release.
    step(1, 0, 1, 0, "rst_setup");
    psel = 1'b1; penable = 1'b1;
    async_reset("rst_mid");
    step(1, 0, 0, 1, "post_rst_setup");
    step(1, 1, 0, 1, "post_rst_acc");
    step(0, 0, 0, 0, "post_rst_idle");

    // Randomized transfers with random aborts, gaps and occasional resets.
    for (int t = 0; t < 150; t++) begin
      logic w, er;
      int gap, setup_len, en_len;
      w = 1'($urandom_range(0, 1));
      er = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      setup_len = $urandom_range(1, 2);
      en_len = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        step(1'($urandom_range(0, 1)) & 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_noise");
      end
      for (int s = 0; s < setup_len; s++) step(1, 0, w, er, "rnd_setup");
      for (int e = 0; e < en_len; e++) step(1, 1, w, er, "rnd_access");
      if ($urandom_range(0, 29) == 0) async_reset("rnd_reset");
    end
    step(0, 0, 0, 0, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #20ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
